// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for mod_n_updown_counter: count controls in, count and flags out.
interface mod_n_updown_counter_if #(
   parameter int unsigned WIDTH = 4
) ();
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] cnt;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up_dn, load, load_val,
      input  cnt, tc, wrap
   );

   modport slave (
      input  en, up_dn, load, load_val,
      output cnt, tc, wrap
   );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Parametrised synchronous modulo-N up/down counter with load, terminal-count and wrap flags.
// Define MOD_N_CNT_SAT_EN to saturate at the limits instead of wrapping (wrap then stays 0).
module mod_n_updown_counter #(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 64'd16
) (
   input logic                   clk,
   input logic                   rst,
   mod_n_updown_counter_if.slave bus
);

   localparam longint unsigned  MOD_LIMIT = 64'd1 << WIDTH;
   localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 64'd1);

`ifdef MOD_N_CNT_SAT_EN
   localparam bit SAT_MODE = 1'b1;
`else
   localparam bit SAT_MODE = 1'b0;
`endif

   // Value taken when a count step runs past a limit: the same limit when saturating.
   localparam logic [WIDTH-1:0] ROLL_UP_VAL = SAT_MODE ? MAX_VAL : '0;
   localparam logic [WIDTH-1:0] ROLL_DN_VAL = SAT_MODE ? '0 : MAX_VAL;

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("mod_n_updown_counter: WIDTH=%0d outside 2..32", WIDTH);
   end
   if (MODULUS < 64'd2 || MODULUS > MOD_LIMIT) begin : g_bad_modulus
      $error("mod_n_updown_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
   end

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             roll_c;
   logic             at_top;
   logic             at_bot;

   assign at_top = (cnt_q == MAX_VAL);
   assign at_bot = (cnt_q == '0);

   // Next count: load beats enable, enable beats hold.
   always_comb begin
      cnt_d  = cnt_q;
      roll_c = 1'b0;
      if (bus.load) begin
         cnt_d = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
      end else if (bus.en) begin
         if (bus.up_dn) begin
            if (at_top) begin
               cnt_d  = ROLL_UP_VAL;
               roll_c = 1'b1;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (at_bot) begin
               cnt_d  = ROLL_DN_VAL;
               roll_c = 1'b1;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
      wrap_d = roll_c & ~SAT_MODE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   // Terminal count looks ahead at the coming edge so it can enable a cascaded stage.
   assign bus.tc   = bus.en & ~bus.load &
                     ((bus.up_dn & at_top) | (~bus.up_dn & at_bot));
   assign bus.cnt  = cnt_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench for mod_n_updown_counter: directed plan followed by random stimulus vs. an arithmetic model.
`timescale 1ns/1ps
module tb_mod_n_updown_counter;

   localparam int unsigned W = 4;
`ifdef MOD_N_CNT_SAT_EN
   localparam int MOD = 16;
   localparam bit SAT = 1'b1;
`else
   localparam int MOD = 10;
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_cnt    = 0;
   bit   m_wrap   = 1'b0;

   mod_n_updown_counter_if #(.WIDTH(W)) bus ();

   mod_n_updown_counter #(.WIDTH(W), .MODULUS(64'(MOD))) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: check tc against the model before the edge, then cnt/wrap after it.
   task automatic step();
      int  nxt;
      bit  rolled;
      bit  exp_tc;
      #1;
      exp_tc = bus.en && !bus.load &&
               ((bus.up_dn && m_cnt == MOD - 1) || (!bus.up_dn && m_cnt == 0));
      chk("tc", 32'(bus.tc), 32'(exp_tc));
      @(posedge clk);
      if (bus.load) begin
         m_cnt  = (int'(bus.load_val) > MOD - 1) ? MOD - 1 : int'(bus.load_val);
         m_wrap = 1'b0;
      end else if (bus.en) begin
         nxt    = bus.up_dn ? m_cnt + 1 : m_cnt - 1;
         rolled = (nxt < 0) || (nxt >= MOD);
         if (SAT) m_cnt = (nxt < 0) ? 0 : ((nxt >= MOD) ? MOD - 1 : nxt);
         else     m_cnt = (nxt + MOD) % MOD;
         m_wrap = rolled && !SAT;
      end else begin
         m_wrap = 1'b0;
      end
      #1;
      chk("cnt", 32'(bus.cnt), 32'(m_cnt));
      chk("wrap", 32'(bus.wrap), 32'(m_wrap));
   endtask

   task automatic drive(input bit en, input bit up_dn, input bit load, input int val);
      bus.en       = en;
      bus.up_dn    = up_dn;
      bus.load     = load;
      bus.load_val = W'(val);
   endtask

   initial begin
      drive(0, 1, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_cnt", 32'(bus.cnt), 32'd0);
      chk("reset_wrap", 32'(bus.wrap), 32'd0);
      rst = 1'b1;

      // Count to 7, then assert reset between edges.
      drive(1, 1, 0, 0);
      repeat (7) step();
      chk("pre_reset_cnt", 32'(bus.cnt), 32'd7);
      #2;
      bus.up_dn = 1'b0;
      rst = 1'b0;
      #1;
      m_cnt  = 0;
      m_wrap = 1'b0;
      chk("async_reset_cnt", 32'(bus.cnt), 32'd0);
      chk("async_reset_wrap", 32'(bus.wrap), 32'd0);
      chk("reset_tc_down", 32'(bus.tc), 32'd1);
      bus.up_dn = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_held_cnt", 32'(bus.cnt), 32'd0);
      #2;
      rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("post_reset_seq", 32'(bus.cnt), 32'(k));
      end

      // Up count through the roll-over.
      drive(1, 1, 1, 0);
      step();
      drive(1, 1, 0, 0);
      repeat (MOD + 2) step();

      // Down count through zero.
      drive(0, 0, 1, 2);
      step();
      drive(1, 0, 0, 0);
      repeat (4) step();

      // Load priority, clamp, and load masking tc at the top.
      drive(1, 1, 1, 6);
      step();
      chk("load_6", 32'(bus.cnt), 32'd6);
      drive(1, 0, 1, 13);
      step();
      drive(1, 1, 1, MOD - 1);
      step();
      step();

      // Hold, then flip direction every cycle.
      drive(0, 1, 1, 4);
      step();
      drive(0, 1, 0, 0);
      repeat (5) step();
      for (int k = 0; k < 4; k++) begin
         drive(1, (k % 2) == 0, 0, 0);
         step();
      end

      // Limits from near the top and near the bottom.
      drive(0, 1, 1, 14);
      step();
      drive(1, 1, 0, 0);
      repeat (3) step();
      drive(0, 0, 1, 1);
      step();
      drive(1, 0, 0, 0);
      repeat (2) step();

      // Random traffic with occasional asynchronous reset pulses.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
               $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
         if ((i % 97) == 50) begin
            #2;
            rst = 1'b0;
            #1;
            m_cnt  = 0;
            m_wrap = 1'b0;
            chk("rand_reset_cnt", 32'(bus.cnt), 32'd0);
            chk("rand_reset_wrap", 32'(bus.wrap), 32'd0);
            @(posedge clk);
            #2;
            rst = 1'b1;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
- Parametrised synchronous modulo-N up/down counter. It is the successor to the fixed 4-bit ripple up counter.
- All state bits are clocked by the single clk; there are no derived clocks.
- Adds programmable width and modulus, direction control, count enable, parallel load, terminal-count and wrap flags.
- Used as the general counter primitive for dividers, timers and address generators.

Parameters:
- WIDTH, 4: counter width in bits. Legal range 2..32.
- MODULUS, 16: count range is 0..MODULUS-1. Legal range 2..2**WIDTH; elaboration fails outside it.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; counter advances one step per clk when high.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- cnt  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational from registered state and inputs.
- wrap  output  1  one-cycle registered pulse marking a roll-over.

Behaviour:
- Reset:
  - rst low asserts immediately, without a clock edge: cnt=0, wrap=0.
  - tc follows its equation from cnt=0.
  - On rst release, the first active edge is the first clk rise with rst high.
  - rst low mid-count aborts the count; no wrap pulse is produced.
- Priority per clk edge: load > en > hold.
- Load:
  - load=1 sets cnt <= load_val, regardless of en and up_dn.
  - If load_val > MODULUS-1, cnt <= MODULUS-1 (clamp).
  - Load never sets wrap; wrap <= 0 that cycle.
- Counting (load=0, en=1):
  - Up: cnt==MODULUS-1 -> cnt <= 0, wrap <= 1; otherwise cnt <= cnt+1.
  - Down: cnt==0 -> cnt <= MODULUS-1, wrap <= 1; otherwise cnt <= cnt-1.
- Hold (load=0, en=0): cnt unchanged; wrap <= 0.
- wrap is high for exactly one cycle, on the cycle after the roll-over edge, i.e. while cnt shows the wrapped value.
- tc = en & ~load & ((up_dn & cnt==MODULUS-1) | (~up_dn & cnt==0)). High exactly when the next edge will wrap, so it is usable for cascading into a following stage's en.
- Direction change mid-count takes effect on the next edge with no extra latency. Example: up_dn flips 1->0 at cnt=5 with en=1; next cnt=4.
- Arithmetic is modulo MODULUS, not 2**WIDTH. For MODULUS=2**WIDTH the behaviour equals natural binary wrap.
- Latency: cnt updates on the same edge that samples en/load; there are no pipeline stages.

Optional Feature:
- Macro: MOD_N_CNT_SAT_EN.
- Defined: saturating mode.
  - Up count at MODULUS-1 holds at MODULUS-1; down count at 0 holds at 0.
  - wrap is never asserted; it is tied 0.
  - tc still asserts at the limit with the same equation, indicating "at limit while enabled".
  - Load and clamp behaviour are unchanged.
- Not defined: wrapping mode as described in Behaviour.

Test Plan (WIDTH=4, MODULUS=10 unless noted):
- Reset: hold rst=0 mid-count at cnt=7, no clk edge -> cnt=0 and wrap=0 immediately. Release rst, en=1, up_dn=1 -> 1,2,3 on successive edges.
- Up wrap: en=1, up_dn=1 from 0.
  - tc=1 only while cnt=9.
  - Next edge cnt=0 and wrap=1 for one cycle.
  - Sequence 0..9,0,1.
- Down wrap: load 2, then en=1, up_dn=0 -> 1, 0, 9 with wrap=1 at cnt=9, then 8. tc=1 while cnt=0.
- Load priority and clamp:
  - load=1, en=1, load_val=6 -> cnt=6, wrap=0.
  - load_val=13 -> cnt=9.
  - load=1 while cnt=9, up_dn=1, en=1 -> tc=0 and no wrap.
- Hold and direction flip:
  - en=0 for 5 cycles at cnt=4 -> cnt stays 4, tc=0.
  - en=1, toggle up_dn every cycle from 4 -> 5, 4, 5, 4.
- MOD_N_CNT_SAT_EN defined, MODULUS=16: count up from 14 -> 15, 15, 15 with wrap=0 and tc=1 at 15. Down from 1 -> 0, 0.
